// File: rtl/elbeth_memory_responder.sv
// elbeth_memory_responder
// Dual-port word memory behind the processor memory bridge. Port A serves
// instruction fetch and port B serves data load/store. Each port runs its own
// IDLE/WAIT/RESP handshake with LATENCY cycles from accept to ready. Writes
// use byte strobes, and out-of-range word addresses return an error.
// Optional build macro: ELBETH_MEM_ROM_PROTECT_EN. When it is defined, words
// below ROM_WORDS reject writes and return an error.
//
// state | meaning
// IDLE  | waiting for en; the request is accepted on the next clk edge
// WAIT  | counting down the remaining wait states
// RESP  | ready is high for one cycle with in_data and error valid
module elbeth_memory_responder #(
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 1,
    parameter int ROM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        amem_en,
    input  logic [7:0]  amem_addr,
    input  logic [31:0] amem_out_data,
    input  logic [3:0]  amem_rw,
    output logic [31:0] amem_in_data,
    output logic        amem_ready,
    output logic        amem_error,
    input  logic        bmem_en,
    input  logic [7:0]  bmem_addr,
    input  logic [31:0] bmem_out_data,
    input  logic [3:0]  bmem_rw,
    output logic [31:0] bmem_in_data,
    output logic        bmem_ready,
    output logic        bmem_error
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
`ifdef ELBETH_MEM_ROM_PROTECT_EN
    localparam bit ROM_PROTECT = 1'b1;
`else
    localparam bit ROM_PROTECT = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t      a_state, b_state;
    logic [3:0]  a_cnt, b_cnt;
    logic [31:0] a_pend_data, b_pend_data;
    logic        a_pend_err, b_pend_err;

    logic        a_in_range, a_rom_hit, a_err_now, a_we;
    logic        b_in_range, b_rom_hit, b_err_now, b_we;
    logic [31:0] a_word, b_word;

    // Decode each port's request. The word is read before the edge, so a read
    // always sees the old data, even when the other port writes the same word.
    always_comb begin
        a_in_range = ({24'd0, amem_addr} < 32'(DEPTH));
        a_rom_hit  = ROM_PROTECT && (amem_rw != 4'd0) && ({24'd0, amem_addr} < 32'(ROM_WORDS));
        a_word     = a_in_range ? mem[amem_addr[AW-1:0]] : 32'd0;
        a_err_now  = !a_in_range || a_rom_hit;
        a_we       = (a_state == ST_IDLE) && amem_en && (amem_rw != 4'd0) && !a_err_now;

        b_in_range = ({24'd0, bmem_addr} < 32'(DEPTH));
        b_rom_hit  = ROM_PROTECT && (bmem_rw != 4'd0) && ({24'd0, bmem_addr} < 32'(ROM_WORDS));
        b_word     = b_in_range ? mem[bmem_addr[AW-1:0]] : 32'd0;
        b_err_now  = !b_in_range || b_rom_hit;
        b_we       = (b_state == ST_IDLE) && bmem_en && (bmem_rw != 4'd0) && !b_err_now;
    end

    // Byte-lane writes are committed at the accept edge. Port B is assigned
    // last, so it wins on lanes that both ports strobe for the same word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (a_we && amem_rw[i]) begin
                mem[amem_addr[AW-1:0]][8*i +: 8] <= amem_out_data[8*i +: 8];
            end
            if (b_we && bmem_rw[i]) begin
                mem[bmem_addr[AW-1:0]][8*i +: 8] <= bmem_out_data[8*i +: 8];
            end
        end
    end

    // Port A handshake FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state      <= ST_IDLE;
            a_cnt        <= 4'd0;
            a_pend_data  <= 32'd0;
            a_pend_err   <= 1'b0;
            amem_in_data <= 32'd0;
            amem_ready   <= 1'b0;
            amem_error   <= 1'b0;
        end else begin
            case (a_state)
                ST_IDLE: begin
                    amem_ready <= 1'b0;
                    if (amem_en) begin
                        if (LATENCY == 1) begin
                            a_state      <= ST_RESP;
                            amem_ready   <= 1'b1;
                            amem_error   <= a_err_now;
                            amem_in_data <= a_word;
                        end else begin
                            a_state     <= ST_WAIT;
                            a_cnt       <= CNT_INIT;
                            a_pend_data <= a_word;
                            a_pend_err  <= a_err_now;
                        end
                    end
                end
                ST_WAIT: begin
                    if (a_cnt == 4'd1) begin
                        a_state      <= ST_RESP;
                        a_cnt        <= 4'd0;
                        amem_ready   <= 1'b1;
                        amem_error   <= a_pend_err;
                        amem_in_data <= a_pend_data;
                    end else begin
                        a_cnt <= a_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    amem_ready <= 1'b0;
                    a_state    <= ST_IDLE;
                end
                default: begin
                    amem_ready <= 1'b0;
                    a_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Port B handshake FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state      <= ST_IDLE;
            b_cnt        <= 4'd0;
            b_pend_data  <= 32'd0;
            b_pend_err   <= 1'b0;
            bmem_in_data <= 32'd0;
            bmem_ready   <= 1'b0;
            bmem_error   <= 1'b0;
        end else begin
            case (b_state)
                ST_IDLE: begin
                    bmem_ready <= 1'b0;
                    if (bmem_en) begin
                        if (LATENCY == 1) begin
                            b_state      <= ST_RESP;
                            bmem_ready   <= 1'b1;
                            bmem_error   <= b_err_now;
                            bmem_in_data <= b_word;
                        end else begin
                            b_state     <= ST_WAIT;
                            b_cnt       <= CNT_INIT;
                            b_pend_data <= b_word;
                            b_pend_err  <= b_err_now;
                        end
                    end
                end
                ST_WAIT: begin
                    if (b_cnt == 4'd1) begin
                        b_state      <= ST_RESP;
                        b_cnt        <= 4'd0;
                        bmem_ready   <= 1'b1;
                        bmem_error   <= b_pend_err;
                        bmem_in_data <= b_pend_data;
                    end else begin
                        b_cnt <= b_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    bmem_ready <= 1'b0;
                    b_state    <= ST_IDLE;
                end
                default: begin
                    bmem_ready <= 1'b0;
                    b_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elbeth_memory_responder.sv
// Self-checking bench for elbeth_memory_responder (DEPTH=128, LATENCY=3).
// Stimulus predicts every response from a word-array model when the request
// is accepted and queues it. A monitor checks responses as they appear.
module tb_elbeth_memory_responder;

    localparam int DEPTH     = 128;
    localparam int LATENCY   = 3;
    localparam int ROM_WORDS = 64;
`ifdef ELBETH_MEM_ROM_PROTECT_EN
    localparam bit ROM_EN = 1'b1;
`else
    localparam bit ROM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        amem_en = 1'b0, bmem_en = 1'b0;
    logic [7:0]  amem_addr = 8'd0, bmem_addr = 8'd0;
    logic [31:0] amem_out_data = 32'd0, bmem_out_data = 32'd0;
    logic [3:0]  amem_rw = 4'd0, bmem_rw = 4'd0;
    logic [31:0] amem_in_data, bmem_in_data;
    logic        amem_ready, bmem_ready, amem_error, bmem_error;

    elbeth_memory_responder #(
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .ROM_WORDS (ROM_WORDS)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .amem_en       (amem_en),
        .amem_addr     (amem_addr),
        .amem_out_data (amem_out_data),
        .amem_rw       (amem_rw),
        .amem_in_data  (amem_in_data),
        .amem_ready    (amem_ready),
        .amem_error    (amem_error),
        .bmem_en       (bmem_en),
        .bmem_addr     (bmem_addr),
        .bmem_out_data (bmem_out_data),
        .bmem_rw       (bmem_rw),
        .bmem_in_data  (bmem_in_data),
        .bmem_ready    (bmem_ready),
        .bmem_error    (bmem_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
        logic        chk;
    } resp_t;

    resp_t       qa[$];
    resp_t       qb[$];
    logic [31:0] mem_m [256];
    bit          known [256];
    int          a_free = 0;
    int          b_free = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected response computed from the memory contents before this edge.
    function automatic void predict(input logic [7:0] addr, input logic [3:0] rw, input int due, output resp_t r);
        bit oor;
        bit rom;
        oor    = int'(addr) >= DEPTH;
        rom    = ROM_EN && (rw != 4'd0) && (int'(addr) < ROM_WORDS);
        r.due  = due;
        r.err  = oor || rom;
        r.data = oor ? 32'd0 : mem_m[addr];
        r.chk  = oor || known[addr];
    endfunction

    function automatic void commit(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] rw);
        if (int'(addr) >= DEPTH || rw == 4'd0 || (ROM_EN && int'(addr) < ROM_WORDS)) return;
        for (int i = 0; i < 4; i++) begin
            if (rw[i]) mem_m[addr][8*i +: 8] = data[8*i +: 8];
        end
        if (rw == 4'hF) known[addr] = 1'b1;
    endfunction

    // Present one cycle of inputs. This task is called just after a negedge.
    // A port accepts when it is free at the coming edge.
    task automatic drive(input logic ae, input logic [7:0] aa, input logic [31:0] ad, input logic [3:0] ar,
                         input logic be, input logic [7:0] ba, input logic [31:0] bd, input logic [3:0] br);
        int    k;
        bit    acc_a, acc_b;
        resp_t ra, rb;
        k = cyc + 1;
        amem_en = ae; amem_addr = aa; amem_out_data = ad; amem_rw = ar;
        bmem_en = be; bmem_addr = ba; bmem_out_data = bd; bmem_rw = br;
        acc_a = ae && (k >= a_free);
        acc_b = be && (k >= b_free);
        if (acc_a) begin
            predict(aa, ar, k + LATENCY - 1, ra);
            qa.push_back(ra);
            a_free = k + LATENCY + 1;
        end
        if (acc_b) begin
            predict(ba, br, k + LATENCY - 1, rb);
            qb.push_back(rb);
            b_free = k + LATENCY + 1;
        end
        if (acc_a) commit(aa, ad, ar);
        if (acc_b) commit(ba, bd, br);
        @(negedge clk);
    endtask

    task automatic idle_until_free();
        int guard;
        guard = 0;
        while ((cyc + 1 < a_free || cyc + 1 < b_free) && guard < 100) begin
            drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0, 32'd0, 4'd0);
            guard++;
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_a_ready"}, 32'(amem_ready), 32'd0);
        check({tag, "_a_error"}, 32'(amem_error), 32'd0);
        check({tag, "_a_data"},  amem_in_data,    32'd0);
        check({tag, "_b_ready"}, 32'(bmem_ready), 32'd0);
        check({tag, "_b_error"}, 32'(bmem_error), 32'd0);
        check({tag, "_b_data"},  bmem_in_data,    32'd0);
    endtask

    task automatic mon(input bit p, input logic rdy, input logic err, input logic [31:0] d);
        resp_t e;
        string nm;
        int    pend;
        nm   = p ? "b" : "a";
        pend = p ? qb.size() : qa.size();
        if (rdy) begin
            if (pend == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL %s_spurious_ready: ready=1 with nothing pending, required ready=0 (cycle %0d)", nm, cyc);
            end else begin
                if (p) e = qb.pop_front();
                else   e = qa.pop_front();
                check({nm, "_ready_cycle"}, 32'(cyc), 32'(e.due));
                check({nm, "_error"}, 32'(err), 32'(e.err));
                if (e.chk) check({nm, "_data"}, d, e.data);
            end
        end else if (pend > 0) begin
            if (p) e = qb[0];
            else   e = qa[0];
            if (e.due <= cyc) begin
                n_vec++;
                n_fail++;
                $display("FAIL %s_late_ready: ready=0 at cycle %0d, required ready=1 at cycle %0d", nm, cyc, e.due);
                if (p) void'(qb.pop_front());
                else   void'(qa.pop_front());
            end
        end
    endtask

    // Response monitor: samples 1 time unit after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                mon(1'b0, amem_ready, amem_error, amem_in_data);
                mon(1'b1, bmem_ready, bmem_error, bmem_in_data);
            end
        end
    end

    initial begin
        logic [7:0]  ra_addr, rb_addr;
        logic [3:0]  ra_rw, rb_rw;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the array so later reads have known contents.
        for (int w = 0; w < DEPTH; w += 2) begin
            drive(1'b1, 8'(w), $urandom, 4'hF, 1'b1, 8'(w + 1), $urandom, 4'hF);
            idle_until_free();
        end

        // Full-word write, readback, then a byte-strobed merge.
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF); idle_until_free();
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h10, 32'd0, 4'h0);        idle_until_free();
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h10, 32'h11223344, 4'b0101); idle_until_free();
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h10, 32'd0, 4'h0);        idle_until_free();

        // en held high on port A: one accept every LATENCY+1 cycles.
        for (int i = 0; i < 12; i++) drive(1'b1, 8'h04, 32'd0, 4'h0, 1'b0, 8'd0, 32'd0, 4'd0);
        idle_until_free();

        // Out-of-range access, then the last valid word.
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h80, 32'd0, 4'h0); idle_until_free();
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h7F, 32'd0, 4'h0); idle_until_free();

        // Both ports write the same word on the same edge, then read it back.
        drive(1'b1, 8'h20, 32'hAAAAAAAA, 4'hF, 1'b1, 8'h20, 32'h55555555, 4'h3); idle_until_free();
        drive(1'b1, 8'h20, 32'd0, 4'h0, 1'b0, 8'd0, 32'd0, 4'd0); idle_until_free();

        // Reset during WAIT of a write: no response, but the write is kept.
        drive(1'b1, 8'h30, 32'h12345678, 4'hF, 1'b0, 8'd0, 32'd0, 4'd0);
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0, 32'd0, 4'd0);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        a_free = 0;
        b_free = 0;
        #1;
        chk_zero("midreset");
        repeat (2) @(negedge clk);
        chk_zero("holdreset");
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h30, 32'd0, 4'h0); idle_until_free();

        // Write into the low (possibly protected) region, then read it back.
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h05, 32'hFFFFFFFF, 4'hF); idle_until_free();
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h05, 32'd0, 4'h0);        idle_until_free();

        // Random traffic focused on a small address window to force collisions.
        for (int i = 0; i < 1500; i++) begin
            ra_addr = ($urandom_range(0, 9) < 6) ? 8'($urandom_range(32, 39)) : 8'($urandom_range(0, 255));
            rb_addr = ($urandom_range(0, 9) < 6) ? 8'($urandom_range(32, 39)) : 8'($urandom_range(0, 255));
            ra_rw   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            rb_rw   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            drive($urandom_range(0, 3) != 0, ra_addr, $urandom, ra_rw,
                  $urandom_range(0, 3) != 0, rb_addr, $urandom, rb_rw);
        end
        idle_until_free();
        repeat (4) drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0, 32'd0, 4'd0);

        check("a_pending_left", 32'(qa.size()), 32'd0);
        check("b_pending_left", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
